// File: rtl/i_ram_load_controller_if.sv
// Loader bundle: byte stream, CPU fetch address and instruction RAM ports.
// slave = controller side, master = host/CPU/RAM side.
interface i_ram_load_controller_if #(
    parameter int ADDRESS_WIDTH = 10
);
    logic                     load_request;
    logic [7:0]               byte_in;
    logic                     byte_valid;
    logic                     byte_ready;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ADDRESS_WIDTH-1:0] i_ram_writing_address;
    logic [31:0]              i_ram_input;
    logic                     flag_write_i_ram;
    logic                     cpu_stall;
    logic                     load_done;
    logic                     load_error;
    logic [ADDRESS_WIDTH:0]   words_loaded;

    modport slave (
        input  load_request, byte_in, byte_valid, cpu_address,
        output byte_ready, address, i_ram_writing_address,
        output i_ram_input, flag_write_i_ram, cpu_stall,
        output load_done, load_error, words_loaded
    );

    modport master (
        output load_request, byte_in, byte_valid, cpu_address,
        input  byte_ready, address, i_ram_writing_address,
        input  i_ram_input, flag_write_i_ram, cpu_stall,
        input  load_done, load_error, words_loaded
    );
endinterface

// File: rtl/i_ram_load_controller.sv
// Byte-stream program loader and I-RAM arbiter between loader and CPU fetch.
// Define I_RAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module i_ram_load_controller #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int MAX_WORDS     = 1024
) (
    input logic                     clock,
    input logic                     reset,
    i_ram_load_controller_if.slave  bus
);
`ifdef I_RAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, COUNT_HI, COUNT_LO, DATA, WRITE, CHECK, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              count_q, count_d;
    logic [23:0]              word_q, word_d;
    logic [1:0]               idx_q, idx_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH:0]   words_q, words_d;
    logic                     err_q, err_d;
    logic [7:0]               csum_q, csum_d;
    logic                     flag_q, flag_d;
    logic                     done_q, done_d;
    logic                     stall_q, stall_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [15:0]              count_full;
    logic                     xfer;

    assign bus.byte_ready = (state_q == COUNT_HI) || (state_q == COUNT_LO) ||
                            (state_q == DATA) || (state_q == CHECK);
    // Stalled fetch is pinned to 0 so the CPU restarts at the reset vector.
    assign bus.address    = (state_q == IDLE) ? bus.cpu_address : '0;

    assign xfer       = bus.byte_valid && bus.byte_ready;
    assign count_full = {count_q[15:8], bus.byte_in};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        err_d   = err_q;
        csum_d  = csum_q;
        flag_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_request) begin
                    state_d = COUNT_HI;
                    err_d   = 1'b0;
                    words_d = '0;
                    ptr_d   = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            COUNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = bus.byte_in;
                    csum_d        = csum_q ^ bus.byte_in;
                    state_d       = COUNT_LO;
                end
            end
            COUNT_LO: begin
                if (xfer) begin
                    count_d = count_full;
                    csum_d  = csum_q ^ bus.byte_in;
                    if (count_full == 16'd0) begin
                        state_d = CSUM_EN ? CHECK : DONE;
                    end else if (32'(count_full) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    word_d = {word_q[15:0], bus.byte_in};
                    csum_d = csum_q ^ bus.byte_in;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                        flag_d  = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = {word_q, bus.byte_in};
                    end
                end
            end
            WRITE: begin
                ptr_d   = ptr_q + 1'b1;
                words_d = words_q + 1'b1;
                if (32'(words_q) + 32'd1 == 32'(count_q)) begin
                    state_d = CSUM_EN ? CHECK : DONE;
                end else begin
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (bus.byte_in != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d  = (state_d == DONE) && !err_d;
        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            csum_q  <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            err_q   <= err_d;
            csum_q  <= csum_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.i_ram_writing_address = waddr_q;
    assign bus.i_ram_input           = wdata_q;
    assign bus.flag_write_i_ram      = flag_q;
    assign bus.cpu_stall             = stall_q;
    assign bus.load_done             = done_q;
    assign bus.load_error            = err_q;
    assign bus.words_loaded          = words_q;
endmodule

// File: tb/tb_i_ram_load_controller.sv
// Scoreboard bench for i_ram_load_controller: expected RAM writes are queued
// as bytes are sent and popped when the DUT pulses flag_write_i_ram.
module tb_i_ram_load_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   wr_cnt = 0;

    logic [41:0] exp_q[$];
    logic [31:0] ram [1024];
    logic [31:0] data_buf [4];

    i_ram_load_controller_if #(.ADDRESS_WIDTH(10)) bus();

    i_ram_load_controller #(
        .ADDRESS_WIDTH(10),
        .MAX_WORDS(1024)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        logic [41:0] e;
        if (bus.load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.flag_write_i_ram) begin
            wr_cnt++;
            ram[bus.i_ram_writing_address] = bus.i_ram_input;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got %h@%h required none",
                         bus.i_ram_input, bus.i_ram_writing_address);
            end else begin
                e = exp_q.pop_front();
                if ({bus.i_ram_writing_address, bus.i_ram_input} !== e) begin
                    fails++;
                    $display("FAIL write got %h@%h required %h@%h",
                             bus.i_ram_input, bus.i_ram_writing_address,
                             e[31:0], e[41:32]);
                end
            end
            checks++;
            if (bus.byte_ready !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write got %b required 0", bus.byte_ready);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (!bus.byte_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!bus.byte_ready) begin
            checks++;
            fails++;
            $display("FAIL byte_timeout got ready=0 required 1 byte %h", b);
            bus.byte_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_request(output int c0);
        @(posedge clock); #1;
        bus.load_request = 1'b1;
        c0 = cyc;
        @(posedge clock); #1;
        bus.load_request = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] cnt, input int nwords,
                           input int gap, input bit bad, output int c0,
                           output logic stall_s, output logic [9:0] addr_s);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        pulse_request(c0);
        stall_s = bus.cpu_stall;
        addr_s  = bus.address;
        send_byte(cnt[15:8], gap);
        cs ^= cnt[15:8];
        send_byte(cnt[7:0], gap);
        cs ^= cnt[7:0];
        for (int i = 0; i < nwords; i++) begin
            if (int'(cnt) <= 1024)
                exp_q.push_back({10'(i), data_buf[i]});
            for (int k = 0; k < 4; k++) begin
                b = data_buf[i][31-8*k -: 8];
                send_byte(b, gap);
                cs ^= b;
            end
        end
`ifdef I_RAM_LOADER_CHECKSUM_EN
        if (int'(cnt) <= 1024)
            send_byte(cs ^ (bad ? 8'h03 : 8'h00), gap);
`else
        if (bad) cs = 8'h00;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cpu_address = 10'h005;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.address !== 10'h005) begin fails++;
            $display("FAIL rst_address got %h required 005", bus.address); end
        checks++; if (bus.cpu_stall !== 1'b0) begin fails++;
            $display("FAIL rst_stall got %b required 0", bus.cpu_stall); end
        checks++; if (bus.byte_ready !== 1'b0) begin fails++;
            $display("FAIL rst_ready got %b required 0", bus.byte_ready); end
        checks++; if (bus.flag_write_i_ram !== 1'b0) begin fails++;
            $display("FAIL rst_flag got %b required 0", bus.flag_write_i_ram); end
        checks++; if (bus.i_ram_writing_address !== 10'h000) begin fails++;
            $display("FAIL rst_waddr got %h required 000", bus.i_ram_writing_address); end
        checks++; if (bus.i_ram_input !== 32'h0) begin fails++;
            $display("FAIL rst_wdata got %h required 0", bus.i_ram_input); end
        checks++; if (bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin fails++;
            $display("FAIL rst_done_err got %b%b required 00", bus.load_done, bus.load_error); end
        checks++; if (bus.words_loaded !== 11'd0) begin fails++;
            $display("FAIL rst_words got %0d required 0", bus.words_loaded); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.address !== 10'h005 || bus.cpu_stall !== 1'b0) begin fails++;
            $display("FAIL idle_addr_stall got %h/%b required 005/0",
                     bus.address, bus.cpu_stall); end
    endtask

    task automatic test_load();
        int c0, d0;
        logic st;
        logic [9:0] ad;
        d0 = done_cnt;
        data_buf[0] = 32'hDEADBEEF;
        data_buf[1] = 32'h01234567;
        do_load(16'd2, 2, 0, 1'b0, c0, st, ad);
        repeat (4) @(posedge clock);
        #1;
        checks++; if (st !== 1'b1 || ad !== 10'h000) begin fails++;
            $display("FAIL load_stall_addr got %b/%h required 1/000", st, ad); end
        checks++; if (done_cnt - d0 !== 1) begin fails++;
            $display("FAIL load_done_cnt got %0d required 1", done_cnt - d0); end
`ifdef I_RAM_LOADER_CHECKSUM_EN
        checks++; if (done_cyc - c0 !== 14) begin fails++;
            $display("FAIL load_latency got %0d required 14", done_cyc - c0); end
`else
        checks++; if (done_cyc - c0 !== 13) begin fails++;
            $display("FAIL load_latency got %0d required 13", done_cyc - c0); end
`endif
        checks++; if (bus.words_loaded !== 11'd2) begin fails++;
            $display("FAIL load_words got %0d required 2", bus.words_loaded); end
        checks++; if (bus.cpu_stall !== 1'b0 || bus.load_error !== 1'b0) begin fails++;
            $display("FAIL load_after got stall %b err %b required 0 0",
                     bus.cpu_stall, bus.load_error); end
        checks++; if (ram[0] !== 32'hDEADBEEF || ram[1] !== 32'h01234567) begin fails++;
            $display("FAIL load_ram got %h %h required deadbeef 01234567",
                     ram[0], ram[1]); end
    endtask

    task automatic test_overflow();
        int c0, d0, w0;
        logic st;
        logic [9:0] ad;
        d0 = done_cnt;
        w0 = wr_cnt;
        do_load(16'h0500, 0, 0, 1'b0, c0, st, ad);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.load_error !== 1'b1) begin fails++;
            $display("FAIL ovf_error got %b required 1", bus.load_error); end
        checks++; if (bus.cpu_stall !== 1'b0 || bus.byte_ready !== 1'b0) begin fails++;
            $display("FAIL ovf_idle got stall %b ready %b required 0 0",
                     bus.cpu_stall, bus.byte_ready); end
        checks++; if (wr_cnt != w0 || done_cnt != d0) begin fails++;
            $display("FAIL ovf_activity got %0d writes %0d done required 0 0",
                     wr_cnt - w0, done_cnt - d0); end
        pulse_request(c0);
        checks++; if (bus.load_error !== 1'b0 || bus.cpu_stall !== 1'b1) begin fails++;
            $display("FAIL ovf_clear got err %b stall %b required 0 1",
                     bus.load_error, bus.cpu_stall); end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef I_RAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        repeat (3) @(posedge clock);
        #1;
        checks++; if (done_cnt - d0 !== 1 || bus.words_loaded !== 11'd0) begin fails++;
            $display("FAIL zero_load got done %0d words %0d required 1 0",
                     done_cnt - d0, bus.words_loaded); end
    endtask

    task automatic test_gapped();
        int c0, d0;
        logic st;
        logic [9:0] ad;
        d0 = done_cnt;
        data_buf[0] = 32'hCAFEF00D;
        do_load(16'd1, 1, 2, 1'b0, c0, st, ad);
        repeat (10) @(posedge clock);
        #1;
        checks++; if (ram[0] !== 32'hCAFEF00D) begin fails++;
            $display("FAIL gap_ram got %h required cafef00d", ram[0]); end
        checks++; if (done_cnt - d0 !== 1 || bus.words_loaded !== 11'd1) begin fails++;
            $display("FAIL gap_done got done %0d words %0d required 1 1",
                     done_cnt - d0, bus.words_loaded); end
    endtask

    task automatic test_reset_midload();
        int c0, d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        pulse_request(c0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        data_buf[0] = 32'hA5A55A5A;
        exp_q.push_back({10'd0, data_buf[0]});
        for (int k = 0; k < 4; k++) send_byte(data_buf[0][31-8*k -: 8], 0);
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        checks++; if (bus.cpu_stall !== 1'b0 || bus.words_loaded !== 11'd0) begin fails++;
            $display("FAIL rstmid_idle got stall %b words %0d required 0 0",
                     bus.cpu_stall, bus.words_loaded); end
        checks++; if (wr_cnt - w0 !== 1 || done_cnt != d0) begin fails++;
            $display("FAIL rstmid_activity got %0d writes %0d done required 1 0",
                     wr_cnt - w0, done_cnt - d0); end
        checks++; if (ram[0] !== 32'hA5A55A5A || ram[1] !== 32'h01234567) begin fails++;
            $display("FAIL rstmid_ram got %h %h required a5a55a5a 01234567",
                     ram[0], ram[1]); end
    endtask

`ifdef I_RAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int c0, d0;
        logic st;
        logic [9:0] ad;
        d0 = done_cnt;
        data_buf[0] = 32'h11223344;
        do_load(16'd1, 1, 0, 1'b0, c0, st, ad);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (done_cnt - d0 !== 1 || bus.load_error !== 1'b0) begin fails++;
            $display("FAIL csum_good got done %0d err %b required 1 0",
                     done_cnt - d0, bus.load_error); end
        d0 = done_cnt;
        do_load(16'd1, 1, 0, 1'b1, c0, st, ad);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (done_cnt != d0 || bus.load_error !== 1'b1) begin fails++;
            $display("FAIL csum_bad got done %0d err %b required 0 1",
                     done_cnt - d0, bus.load_error); end
    endtask
`endif

    initial begin
        bus.load_request = 1'b0;
        bus.byte_in      = 8'h00;
        bus.byte_valid   = 1'b0;
        bus.cpu_address  = 10'h000;
        test_reset();
        test_load();
        test_overflow();
        test_gapped();
        test_reset_midload();
`ifdef I_RAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_writes got %0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
